// File: rtl/accum_pkg.sv
// rtl/accum_pkg.sv - mode encoding, clear FSM state type and default sizes for the accumulator
package accum_pkg;

  localparam logic MODE_OVERWRITE = 1'b0;
  localparam logic MODE_ACC       = 1'b1;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE  = 1'b0;
  localparam state_t ST_CLEAR = 1'b1;

  localparam int DEF_SYS_COL    = 16;
  localparam int DEF_IN_WIDTH   = 32;
  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_ACCUM_SIZE = 4096;

endpackage

// File: rtl/accum_rmw_col.sv
// rtl/accum_rmw_col.sv - one accumulator column: row memory, 2-stage RMW with forwarding, drain read
// Optional clamping of accumulate results under ACCUM_SATURATE_EN; otherwise sums wrap.
module accum_rmw_col
  import accum_pkg::*;
#(
  parameter int IN_WIDTH   = DEF_IN_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACCUM_ROW  = DEF_ACCUM_SIZE / DEF_SYS_COL,
  parameter int ADDR_WIDTH = $clog2(ACCUM_ROW)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_in_en,
  input  logic                  i_flush,
  input  logic                  i_clr_we,
  input  logic [ADDR_WIDTH-1:0] i_clr_addr,
  input  logic                  i_in_valid,
  input  logic                  i_in_acc,
  input  logic [ADDR_WIDTH-1:0] i_in_addr,
  input  logic [IN_WIDTH-1:0]   i_in_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic                  o_rd_valid,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_sat_flag
);

  logic [DATA_WIDTH-1:0] r_mem [ACCUM_ROW];

  logic                  r_s1_valid;
  logic                  r_s1_acc;
  logic [ADDR_WIDTH-1:0] r_s1_addr;
  logic [DATA_WIDTH-1:0] r_s1_old;
  logic [DATA_WIDTH-1:0] r_s1_data;
  logic                  r_rd_valid;
  logic [DATA_WIDTH-1:0] r_rd_data;

  logic                  w_accept;
  logic                  w_s1_we;
  logic                  w_is_acc;
  logic [DATA_WIDTH-1:0] w_sum;
  logic [DATA_WIDTH-1:0] w_s1_result;
  logic [DATA_WIDTH-1:0] w_s0_old;

  assign w_accept = i_in_valid & i_in_en & ~i_flush;
  assign w_s1_we  = r_s1_valid & ~i_flush;
  assign w_is_acc = (r_s1_acc == MODE_ACC);
  assign w_sum    = r_s1_old + r_s1_data;

`ifdef ACCUM_SATURATE_EN
  localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic w_ovf;
  logic r_sat;

  // Signed overflow: both operands share a sign that the sum does not.
  assign w_ovf = w_is_acc && (r_s1_old[DATA_WIDTH-1] == r_s1_data[DATA_WIDTH-1])
                          && (w_sum[DATA_WIDTH-1] != r_s1_old[DATA_WIDTH-1]);
  assign w_s1_result = w_ovf ? (r_s1_old[DATA_WIDTH-1] ? SAT_MIN : SAT_MAX)
                             : (w_is_acc ? w_sum : r_s1_data);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sat <= 1'b0;
    end else if (i_flush) begin
      r_sat <= 1'b0;
    end else if (w_s1_we && w_ovf) begin
      r_sat <= 1'b1;
    end
  end

  assign o_sat_flag = r_sat;
`else
  assign w_s1_result = w_is_acc ? w_sum : r_s1_data;
  assign o_sat_flag  = 1'b0;
`endif

  // Memory is written only at the end of S1, so a same-row beat right behind must take the S1 result.
  assign w_s0_old = (r_s1_valid && (r_s1_addr == i_in_addr)) ? w_s1_result : r_mem[i_in_addr];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1_valid <= 1'b0;
      r_s1_acc   <= 1'b0;
      r_s1_addr  <= '0;
      r_s1_old   <= '0;
      r_s1_data  <= '0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_acc  <= i_in_acc;
        r_s1_addr <= i_in_addr;
        r_s1_old  <= w_s0_old;
        r_s1_data <= DATA_WIDTH'($signed(i_in_data));
      end
      r_rd_valid <= i_rd_en;
      if (i_rd_en) begin
        r_rd_data <= r_mem[i_rd_addr];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_clr_we) begin
      r_mem[i_clr_addr] <= '0;
    end else if (w_s1_we) begin
      r_mem[r_s1_addr] <= w_s1_result;
    end
  end

  assign o_rd_valid = r_rd_valid;
  assign o_rd_data  = r_rd_data;

endmodule

// File: rtl/accum_rmw.sv
// rtl/accum_rmw.sv - multi-column accumulator with zero-clear sweep FSM
// Saturating accumulate is selected per column by ACCUM_SATURATE_EN.
module accum_rmw
  import accum_pkg::*;
#(
  parameter int SYS_COL    = DEF_SYS_COL,
  parameter int IN_WIDTH   = DEF_IN_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACCUM_SIZE = DEF_ACCUM_SIZE,
  localparam int ACCUM_ROW  = ACCUM_SIZE / SYS_COL,
  localparam int ADDR_WIDTH = $clog2(ACCUM_ROW)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 clr_start,
  output logic                                 busy,
  output logic                                 in_ready,
  input  logic [SYS_COL-1:0]                   in_valid,
  input  logic [SYS_COL-1:0]                   in_acc,
  input  logic [SYS_COL-1:0][ADDR_WIDTH-1:0]   in_addr,
  input  logic [SYS_COL-1:0][IN_WIDTH-1:0]     in_data,
  input  logic [SYS_COL-1:0]                   rd_en,
  input  logic [SYS_COL-1:0][ADDR_WIDTH-1:0]   rd_addr,
  output logic [SYS_COL-1:0]                   rd_valid,
  output logic [SYS_COL-1:0][DATA_WIDTH-1:0]   rd_data,
  output logic [SYS_COL-1:0]                   sat_flag
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(ACCUM_ROW - 1);

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic                  w_flush;
  logic                  w_clr_we;

  assign busy     = (r_state == ST_CLEAR);
  assign in_ready = ~busy;
  assign w_clr_we = busy;
  // A clear request drops whatever sits in S1 and any beat offered alongside it.
  assign w_flush  = clr_start && (r_state == ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (clr_start) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
          end
        end
        ST_CLEAR: begin
          if (r_cnt == LAST_ROW) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_CLEAR;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < SYS_COL; g++) begin : g_col
    accum_rmw_col #(
      .IN_WIDTH   (IN_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .ACCUM_ROW  (ACCUM_ROW),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_col (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_in_en    (in_ready),
      .i_flush    (w_flush),
      .i_clr_we   (w_clr_we),
      .i_clr_addr (r_cnt),
      .i_in_valid (in_valid[g]),
      .i_in_acc   (in_acc[g]),
      .i_in_addr  (in_addr[g]),
      .i_in_data  (in_data[g]),
      .i_rd_en    (rd_en[g]),
      .i_rd_addr  (rd_addr[g]),
      .o_rd_valid (rd_valid[g]),
      .o_rd_data  (rd_data[g]),
      .o_sat_flag (sat_flag[g])
    );
  end

endmodule
